// File: rtl/speed_level_pkg.sv
// Shared types and constants for the speed-level controller.
// The STOP state is only reachable when SPEED_EMERG_STOP_EN is defined.
`timescale 1ns/1ps
package speed_level_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam logic [11:0] DEF_THRESH = {4'd12, 4'd8, 4'd3};

  function automatic int lw_of(input int levels);
    return (levels < 1) ? 1 : $clog2(levels + 1);
  endfunction

endpackage

// File: rtl/speed_level_map.sv
// Combinational sensor-code to target-level map: counts how many
// threshold slices the code meets or exceeds.
`timescale 1ns/1ps
module speed_level_map
  import speed_level_pkg::*;
#(
  parameter int                     IN_W   = 4,
  parameter int                     LEVELS = 3,
  parameter logic [LEVELS*IN_W-1:0] THRESH = DEF_THRESH
) (
  input  logic [IN_W-1:0]           code,
  output logic [lw_of(LEVELS)-1:0]  target
);

  localparam int LW = lw_of(LEVELS);

  always_comb begin
    target = '0;
    for (int k = 0; k < LEVELS; k++) begin
      if (code >= THRESH[k*IN_W +: IN_W]) target = target + LW'(1);
    end
  end

endmodule

// File: rtl/speed_level_ctrl.sv
// Debounced, ramped speed-level controller driving one-hot velocity enables.
// Define SPEED_EMERG_STOP_EN to add the estop input and the STOP state.
//
//   state | meaning
//   IDLE  | level == target, waiting for a new target
//   UP    | ramp timer running, next step is toward a higher target
//   DOWN  | ramp timer running, next step is toward a lower target
//   STOP  | emergency stop, level held at 0 until estop low and target 0
`timescale 1ns/1ps
module speed_level_ctrl
  import speed_level_pkg::*;
#(
  parameter int                     IN_W       = 4,
  parameter int                     LEVELS     = 3,
  parameter logic [LEVELS*IN_W-1:0] THRESH     = DEF_THRESH,
  parameter int                     STABLE_CYC = 2,
  parameter int                     RAMP_CYC   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_W-1:0]           in_code,
  input  logic                      en,
`ifdef SPEED_EMERG_STOP_EN
  input  logic                      estop,
`endif
  output logic [LEVELS-1:0]         vel,
  output logic [lw_of(LEVELS)-1:0]  level,
  output logic                      busy
);

  localparam int LW = lw_of(LEVELS);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int TW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(RAMP_CYC - 1);

  logic [IN_W-1:0] samp, acc_code;
  logic [CW-1:0]   stab_cnt;
  logic [LW-1:0]   map_tgt, target, level_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [LEVELS-1:0] vel_nxt;
  logic            busy_nxt;
  state_t          state, state_nxt;

  // Counter tracks how long the newest sample has matched the registered one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp     <= '0;
      stab_cnt <= '0;
      acc_code <= '0;
    end else begin
      samp <= in_code;
      if (in_code != samp) stab_cnt <= CW'(1);
      else if (stab_cnt != CW'(STABLE_CYC)) stab_cnt <= stab_cnt + CW'(1);
      if (stab_cnt == CW'(STABLE_CYC)) acc_code <= samp;
    end
  end

  speed_level_map #(
    .IN_W   (IN_W),
    .LEVELS (LEVELS),
    .THRESH (THRESH)
  ) u_map (
    .code   (acc_code),
    .target (map_tgt)
  );

  assign target = en ? map_tgt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
      timer <= '0;
      vel   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      timer <= timer_nxt;
      vel   <= vel_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (target != level) begin
          state_nxt = (target > level) ? UP : DOWN;
          timer_nxt = T_LOAD;
        end
      end
      UP, DOWN: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end else begin
          // Step toward wherever the target is now, so a reversal never skips a level.
          if (target > level)      level_nxt = level + LW'(1);
          else if (target < level) level_nxt = level - LW'(1);
          if (level_nxt == target) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = (target > level_nxt) ? UP : DOWN;
            timer_nxt = T_LOAD;
          end
        end
      end
`ifdef SPEED_EMERG_STOP_EN
      STOP: begin
        level_nxt = '0;
        timer_nxt = '0;
        if (!estop && target == '0) state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
        level_nxt = '0;
        timer_nxt = '0;
      end
    endcase
`ifdef SPEED_EMERG_STOP_EN
    if (estop) begin
      state_nxt = STOP;
      level_nxt = '0;
      timer_nxt = '0;
    end
`endif
  end

  always_comb begin
    vel_nxt = '0;
    for (int k = 0; k < LEVELS; k++) vel_nxt[k] = (level_nxt == LW'(k + 1));
    busy_nxt = (state_nxt != STOP) && (level_nxt != target);
  end

endmodule

// File: tb/tb_speed_level_ctrl.sv
// Directed bench for speed_level_ctrl with a queue of expected outputs.
// Define SPEED_EMERG_STOP_EN to also exercise the emergency stop.
`timescale 1ns/1ps
module tb_speed_level_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_code = '0;
  logic       en = 1'b0;
  logic [2:0] vel;
  logic [1:0] level;
  logic       busy;
`ifdef SPEED_EMERG_STOP_EN
  logic       estop = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string tag;
    int    lvl;
    bit    bsy;
  } exp_t;

  exp_t sb_q[$];

  speed_level_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_code (in_code),
    .en      (en),
`ifdef SPEED_EMERG_STOP_EN
    .estop   (estop),
`endif
    .vel     (vel),
    .level   (level),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    int   ev;
    e  = sb_q.pop_front();
    ev = (e.lvl == 0) ? 0 : (1 << (e.lvl - 1));
    cmp({e.tag, ".level"}, int'(level), e.lvl);
    cmp({e.tag, ".vel"},   int'(vel),   ev);
    cmp({e.tag, ".busy"},  int'(busy),  int'(e.bsy));
  endtask

  // Expectation is queued when the stimulus is set up, consumed n edges later.
  task automatic exp_after(input int n, input string tag, input int lvl, input bit bsy);
    exp_t e;
    e.tag = tag;
    e.lvl = lvl;
    e.bsy = bsy;
    sb_q.push_back(e);
    tick(n);
    check_front();
  endtask

  task automatic do_reset();
    in_code = '0;
    en      = 1'b0;
    rst_n   = 1'b0;
    tick(2);
    rst_n   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_seen;
    bit lvl_seen;
    tick(1);
    do_reset();
    exp_after(0, "reset", 0, 0);

    // single step to level 1
    in_code = 4'd3; en = 1'b1;
    exp_after(4,  "c3_wait0", 0, 1);
    exp_after(7,  "c3_wait7", 0, 1);
    exp_after(1,  "c3_step",  1, 0);

    // full ramp 0 -> 3
    do_reset();
    in_code = 4'd12; en = 1'b1;
    exp_after(4,  "up_start", 0, 1);
    exp_after(8,  "up_l1",    1, 1);
    exp_after(7,  "up_l1_end",1, 1);
    exp_after(1,  "up_l2",    2, 1);
    exp_after(7,  "up_l2_end",2, 1);
    exp_after(1,  "up_l3",    3, 0);

    // en dropped: ramp 3 -> 0
    en = 1'b0;
    exp_after(1,  "dn_start", 3, 1);
    exp_after(7,  "dn_l3_end",3, 1);
    exp_after(1,  "dn_l2",    2, 1);
    exp_after(8,  "dn_l1",    1, 1);
    exp_after(7,  "dn_l1_end",1, 1);
    exp_after(1,  "dn_l0",    0, 0);

    // one-cycle glitch must be rejected
    in_code = 4'd0;
    tick(4);
    en = 1'b1;
    tick(2);
    in_code = 4'd15;
    tick(1);
    in_code = 4'd0;
    busy_seen = 1'b0;
    lvl_seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) busy_seen = 1'b1;
      if (level != 2'd0) lvl_seen = 1'b1;
    end
    cmp("glitch.busy_seen", int'(busy_seen), 0);
    cmp("glitch.level_moved", int'(lvl_seen), 0);

    // reversal mid-ramp: 2 -> 1 then back to 2
    in_code = 4'd8;
    exp_after(4,  "rv_start", 0, 1);
    exp_after(8,  "rv_l1",    1, 1);
    exp_after(8,  "rv_l2",    2, 0);
    en = 1'b0;
    exp_after(1,  "rv_dn",    2, 1);
    exp_after(8,  "rv_l1b",   1, 1);
    en = 1'b1;
    exp_after(7,  "rv_hold",  1, 1);
    exp_after(1,  "rv_back2", 2, 0);

    // async reset mid-ramp at level 2
    in_code = 4'd12;
    exp_after(6,  "rst_pre",  2, 1);
    rst_n = 1'b0;
    #0.5;
    exp_after(0,  "rst_async", 0, 0);
    #0.5;
    rst_n = 1'b1;
    in_code = 4'd0; en = 1'b0;
    tick(1);

`ifdef SPEED_EMERG_STOP_EN
    do_reset();
    in_code = 4'd12; en = 1'b1;
    exp_after(28, "es_l3",    3, 0);
    estop = 1'b1;
    exp_after(1,  "es_hit",   0, 0);
    tick(1);
    estop = 1'b0;
    exp_after(15, "es_hold",  0, 0);
    in_code = 4'd0;
    tick(6);
    in_code = 4'd12;
    exp_after(4,  "es_rest",  0, 1);
    exp_after(8,  "es_l1",    1, 1);
`endif

    cmp("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_level_ctrl.md
Name: speed_level_ctrl

Overview:
- Registered, parametrised speed-level controller with LEVELS one-hot velocity outputs.
- Samples a raw IN_W-bit sensor code and debounces it over STABLE_CYC cycles.
- Maps the code through programmable thresholds to a target level, then ramps the applied level one step at a time, every RAMP_CYC cycles.
- Sits between the sensor/switch input bank and the motor-drive enables.

Parameters:
- IN_W, 4, width of sensor code.
- LEVELS, 3, number of non-zero speed levels; one output bit each.
- THRESH, {4'd12,4'd8,4'd3}, packed LEVELS×IN_W thresholds. Slice k-1 is the minimum code for level k. Must be strictly ascending.
- STABLE_CYC, 2, consecutive identical samples required to accept a new code (≥1).
- RAMP_CYC, 8, clock cycles per one-level step (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_code  in  IN_W  raw sensor code, synchronous to clk.
- en  in  1  run enable; low forces target to 0.
- vel  out  LEVELS  one-hot applied level; bit k-1 high when level==k; all-zero at level 0.
- level  out  LW=$clog2(LEVELS+1)  applied level, binary.
- busy  out  1  high while level != target.
- estop  in  1  emergency stop; present only with SPEED_EMERG_STOP_EN.

Behaviour:
- Reset (rst_n low, async): level=0, vel=0, busy=0, state=IDLE, filter counter=0, accepted code=0, ramp timer=0.
- Filter: in_code is registered once.
  - Counter increments while the registered sample equals the previous sample; it resets to 1 on change.
  - When the count reaches STABLE_CYC, the accepted code takes the sample.
  - Latency from a stable input to the accepted code: STABLE_CYC+1 cycles.
- Target: number of k in 1..LEVELS with accepted_code ≥ THRESH slice k-1; forced to 0 when en=0. Combinational from registered state.
  - Defaults give codes 0–2 → 0, 3–7 → 1, 8–11 → 2, 12–15 → 3.
- FSM states: IDLE, UP, DOWN.
  - IDLE: if target>level → UP, if target<level → DOWN. Ramp timer is loaded with RAMP_CYC-1 on the transition.
  - UP/DOWN: timer decrements each cycle. At 0, level ±1. Then:
    - if new level==target → IDLE;
    - else if target is still in the same direction, reload the timer;
    - else switch to the other direction, reloading the timer.
  - First step occurs RAMP_CYC cycles after leaving IDLE.
  - Target changing mid-ramp never causes a jump of more than one level per step.
- level saturates at 0 and at LEVELS; no wrap.
- vel and busy are registered and update in the same cycle as level. vel is always one-hot or zero.
- en deassert mid-ramp: target=0; ramps down from the current level through the normal timer. No immediate drop.
- in_code change during a ramp: affects target only after the filter accepts it.
- Async reset mid-ramp: immediate return to reset values. No partial step completes.

Optional Feature:
- Macro SPEED_EMERG_STOP_EN.
- Defined:
  - Adds estop port and STOP state.
  - estop high in any state → next edge: level=0, vel=0, busy=0, state=STOP.
  - Remain in STOP while estop=1 or target!=0.
  - Exit to IDLE when estop=0 and target==0 in the same cycle.
  - estop has priority over all ramp activity.
- Undefined: no estop port; no STOP state; behaviour as above.

Decomposition:
- Package speed_level_pkg holds:
  - state enum (IDLE, UP, DOWN, STOP);
  - LW derivation function;
  - default threshold constant.
- Sub-module speed_level_map: pure combinational code→target mapping (IN_W, LEVELS, THRESH). Instantiated once. Reusable by the monitor and scoreboard.
- Filter, timer and FSM stay in the top module.

Test Plan:
- Reset, then in_code=4'b0011, en=1 held → target 1 after 3 cycles; level=1, vel=3'b001 exactly RAMP_CYC (8) cycles later; busy high during the wait.
- in_code=4'b1100 from level 0 → level steps 0→1→2→3 at 8-cycle intervals; vel 001→010→100; busy drops with level=3.
- 1-cycle glitch of in_code 0→15→0 with STABLE_CYC=2 → accepted code unchanged; level stays 0, busy never asserts.
- At level 3, drop en → ramps 3→2→1→0 at 8-cycle intervals. Then re-raise en with code 8 mid-ramp at level 1 → reverses to 2 after the next timer expiry.
- rst_n low for 1 ns mid-ramp at level 2 → level=0, vel=0, busy=0 asynchronously, before the next edge.
- With SPEED_EMERG_STOP_EN, level 3, estop=1 → level=0 next edge. Release estop with code 12 still applied → stays STOP. Set code 0, then estop=0 → IDLE; a fresh code 12 then ramps normally.
